// File: rtl/regfile_theta_bank.sv
// ---------------------------------------------------------------------------
// regfile_theta_bank
//
// Append-only register bank with in-place update and a registered read port.
// Entries are filled in order (a load always writes entry `count`), existing
// entries may be overwritten through the update port, and reads of entries
// that were never written return zero with an error pulse.
//
// Parameters
//   DATA_W  entry width in bits
//   DEPTH   number of entries (power of two, 2..64)
//   ADDR_W  log2(DEPTH)
//
// Ports
//   clk        single clock, all state changes on its rising edge
//   rst        asynchronous active-high reset
//   clr        synchronous clear of contents and state (beats every other op)
//   load_en    append din at entry `count` unless full
//   din        append data
//   upd_en     overwrite entry upd_addr if it is already valid
//   upd_addr   overwrite index
//   upd_din    overwrite data
//   rd_en      read request
//   rd_addr    read index
//   dout       registered read data
//   dout_valid high for the cycle after an accepted read
//   rd_err     high with dout_valid when the read hit an unwritten entry
//   count      number of valid entries, 0..DEPTH
//   full       count == DEPTH
//   empty      count == 0
//   ovf        sticky: a load was attempted while full
//
// Build option
//   THETA_BANK_TRISTATE_EN  when defined, dout floats whenever dout_valid is
//                           low so several banks can share one bus. Otherwise
//                           dout holds the last read value.
// ---------------------------------------------------------------------------
module regfile_theta_bank #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              load_en,
    input  logic [DATA_W-1:0] din,
    input  logic              upd_en,
    input  logic [ADDR_W-1:0] upd_addr,
    input  logic [DATA_W-1:0] upd_din,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              rd_err,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              ovf
);

    localparam logic [ADDR_W:0] DepthCnt = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] CntOne   = (ADDR_W + 1)'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [ADDR_W:0]   count_q, count_d;
    logic              ovf_q, ovf_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dout_valid_q, dout_valid_d;
    logic              rd_err_q, rd_err_d;

    // ------------------------------------------------------------------
    // Decode, all judged against the pre-edge count
    // ------------------------------------------------------------------
    logic full_w;
    logic empty_w;
    logic load_ok;
    logic load_ovf;
    logic upd_ok;
    logic rd_hit;

    always_comb begin
        full_w   = (count_q == DepthCnt);
        empty_w  = (count_q == '0);
        load_ok  = load_en & ~full_w;
        load_ovf = load_en & full_w;
        upd_ok   = upd_en & ({1'b0, upd_addr} < count_q);
        rd_hit   = ({1'b0, rd_addr} < count_q);
    end

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        mem_d        = mem_q;
        count_d      = count_q;
        ovf_d        = ovf_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        rd_err_d     = 1'b0;

        if (clr) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_d[i] = '0;
            end
            count_d = '0;
            ovf_d   = 1'b0;
            dout_d  = '0;
        end else begin
            // An accepted update targets an index below count and a load
            // targets index count, so the two writes never collide.
            if (upd_ok) begin
                mem_d[upd_addr] = upd_din;
            end
            if (load_ok) begin
                mem_d[count_q[ADDR_W-1:0]] = din;
                count_d = count_q + CntOne;
            end
            if (load_ovf) begin
                ovf_d = 1'b1;
            end
            // Read uses mem_q, so a same-cycle write to the index is not seen.
            if (rd_en) begin
                dout_valid_d = 1'b1;
                if (rd_hit) begin
                    dout_d = mem_q[rd_addr];
                end else begin
                    dout_d   = '0;
                    rd_err_d = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            count_q      <= '0;
            ovf_q        <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            rd_err_q     <= 1'b0;
        end else begin
            mem_q        <= mem_d;
            count_q      <= count_d;
            ovf_q        <= ovf_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            rd_err_q     <= rd_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign dout_valid = dout_valid_q;
    assign rd_err     = rd_err_q;
    assign count      = count_q;
    assign full       = full_w;
    assign empty      = empty_w;
    assign ovf        = ovf_q;

`ifdef THETA_BANK_TRISTATE_EN
    assign dout = dout_valid_q ? dout_q : {DATA_W{1'bz}};
`else
    assign dout = dout_q;
`endif

endmodule

// File: tb/tb_regfile_theta_bank.sv
// ---------------------------------------------------------------------------
// tb_regfile_theta_bank
//
// Directed bench for regfile_theta_bank (DATA_W=32, DEPTH=8). A table of
// one-cycle vectors with hand-computed results covers load, update, read,
// overflow and clear; short hand-written sequences cover read-before-write
// on a fresh bank and asynchronous reset, including reset racing a read.
// ---------------------------------------------------------------------------
module tb_regfile_theta_bank;

    logic        clk;
    logic        rst;
    logic        clr;
    logic        load_en;
    logic [31:0] din;
    logic        upd_en;
    logic [2:0]  upd_addr;
    logic [31:0] upd_din;
    logic        rd_en;
    logic [2:0]  rd_addr;
    logic [31:0] dout;
    logic        dout_valid;
    logic        rd_err;
    logic [3:0]  count;
    logic        full;
    logic        empty;
    logic        ovf;

    int n_cmp = 0;
    int n_bad = 0;

    regfile_theta_bank #(
        .DATA_W(32),
        .DEPTH (8),
        .ADDR_W(3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .load_en   (load_en),
        .din       (din),
        .upd_en    (upd_en),
        .upd_addr  (upd_addr),
        .upd_din   (upd_din),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .dout      (dout),
        .dout_valid(dout_valid),
        .rd_err    (rd_err),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        clr;
        logic        ld;
        logic [31:0] din;
        logic        up;
        logic [2:0]  ua;
        logic [31:0] ud;
        logic        rd;
        logic [2:0]  ra;
        logic [31:0] e_dout;
        logic        e_v;
        logic        e_e;
        logic [3:0]  e_cnt;
        logic        e_ovf;
    } vec_t;

    localparam int NV = 21;
    vec_t tbl [NV];

    function automatic vec_t mk(logic c, logic l, logic [31:0] d, logic u, logic [2:0] ua,
                                logic [31:0] ud, logic r, logic [2:0] ra, logic [31:0] ed,
                                logic ev, logic ee, logic [3:0] ec, logic eo);
        vec_t v;
        v.clr = c;  v.ld = l;  v.din = d;  v.up = u;  v.ua = ua;  v.ud = ud;
        v.rd = r;   v.ra = ra; v.e_dout = ed; v.e_v = ev; v.e_e = ee;
        v.e_cnt = ec; v.e_ovf = eo;
        return v;
    endfunction

    // Idle dout is the held value, or high-impedance in the shared-bus build.
    function automatic logic [31:0] exp_dout(logic v, logic [31:0] d);
`ifdef THETA_BANK_TRISTATE_EN
        return v ? d : 32'hzzzz_zzzz;
`else
        return d;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        clr = 1'b0; load_en = 1'b0; din = '0; upd_en = 1'b0; upd_addr = '0;
        upd_din = '0; rd_en = 1'b0; rd_addr = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [31:0] ed, input logic ev,
                               input logic ee, input logic [3:0] ec, input logic eo);
        chk({tag, ".dout"}, dout, exp_dout(ev, ed));
        chk({tag, ".dout_valid"}, 32'(dout_valid), 32'(ev));
        chk({tag, ".rd_err"}, 32'(rd_err), 32'(ee));
        chk({tag, ".count"}, 32'(count), 32'(ec));
        chk({tag, ".ovf"}, 32'(ovf), 32'(eo));
        chk({tag, ".full"}, 32'(full), 32'(ec == 4'd8));
        chk({tag, ".empty"}, 32'(empty), 32'(ec == 4'd0));
    endtask

    initial begin
        //            clr ld din     up ua   ud      rd ra   dout    v  e  cnt ovf
        tbl[0]  = mk(0, 1, 32'h11, 0, 3'd0, 32'h0,  0, 3'd0, 32'h0,  0, 0, 4'd1, 0);
        tbl[1]  = mk(0, 1, 32'h22, 0, 3'd0, 32'h0,  0, 3'd0, 32'h0,  0, 0, 4'd2, 0);
        // count=2: read and update of index 5 are both out of range
        tbl[2]  = mk(0, 0, 32'h0,  1, 3'd5, 32'h55, 1, 3'd5, 32'h0,  1, 1, 4'd2, 0);
        // read of index 2 judged against pre-edge count 2 while loading it
        tbl[3]  = mk(0, 1, 32'h33, 0, 3'd0, 32'h0,  1, 3'd2, 32'h0,  1, 1, 4'd3, 0);
        tbl[4]  = mk(0, 0, 32'h0,  0, 3'd0, 32'h0,  1, 3'd1, 32'h22, 1, 0, 4'd3, 0);
        tbl[5]  = mk(0, 0, 32'h0,  0, 3'd0, 32'h0,  0, 3'd0, 32'h22, 0, 0, 4'd3, 0);
        // update and read of the same index: old data returned
        tbl[6]  = mk(0, 0, 32'h0,  1, 3'd0, 32'hBB, 1, 3'd0, 32'h11, 1, 0, 4'd3, 0);
        tbl[7]  = mk(0, 0, 32'h0,  0, 3'd0, 32'h0,  1, 3'd0, 32'hBB, 1, 0, 4'd3, 0);
        // load and update together: both land
        tbl[8]  = mk(0, 1, 32'h44, 1, 3'd1, 32'h99, 0, 3'd0, 32'hBB, 0, 0, 4'd4, 0);
        tbl[9]  = mk(0, 0, 32'h0,  0, 3'd0, 32'h0,  1, 3'd3, 32'h44, 1, 0, 4'd4, 0);
        tbl[10] = mk(0, 0, 32'h0,  0, 3'd0, 32'h0,  1, 3'd1, 32'h99, 1, 0, 4'd4, 0);
        tbl[11] = mk(0, 1, 32'h55, 0, 3'd0, 32'h0,  0, 3'd0, 32'h99, 0, 0, 4'd5, 0);
        tbl[12] = mk(0, 1, 32'h66, 0, 3'd0, 32'h0,  0, 3'd0, 32'h99, 0, 0, 4'd6, 0);
        tbl[13] = mk(0, 1, 32'h77, 0, 3'd0, 32'h0,  0, 3'd0, 32'h99, 0, 0, 4'd7, 0);
        tbl[14] = mk(0, 1, 32'h88, 0, 3'd0, 32'h0,  0, 3'd0, 32'h99, 0, 0, 4'd8, 0);
        // load while full: saturates, sets sticky ovf
        tbl[15] = mk(0, 1, 32'hFF, 0, 3'd0, 32'h0,  0, 3'd0, 32'h99, 0, 0, 4'd8, 1);
        tbl[16] = mk(0, 0, 32'h0,  0, 3'd0, 32'h0,  1, 3'd7, 32'h88, 1, 0, 4'd8, 1);
        tbl[17] = mk(0, 0, 32'h0,  1, 3'd7, 32'hC7, 1, 3'd2, 32'h33, 1, 0, 4'd8, 1);
        tbl[18] = mk(0, 0, 32'h0,  0, 3'd0, 32'h0,  1, 3'd7, 32'hC7, 1, 0, 4'd8, 1);
        // clr beats a load and a read in the same cycle
        tbl[19] = mk(1, 1, 32'h12, 0, 3'd0, 32'h0,  1, 3'd0, 32'h0,  0, 0, 4'd0, 0);
        tbl[20] = mk(0, 0, 32'h0,  0, 3'd0, 32'h0,  1, 3'd0, 32'h0,  1, 1, 4'd0, 0);

        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_state("reset", 32'h0, 1'b0, 1'b0, 4'd0, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            clr = tbl[i].clr;  load_en = tbl[i].ld;  din = tbl[i].din;
            upd_en = tbl[i].up; upd_addr = tbl[i].ua; upd_din = tbl[i].ud;
            rd_en = tbl[i].rd;  rd_addr = tbl[i].ra;
            tick();
            check_state($sformatf("vec%0d", i), tbl[i].e_dout, tbl[i].e_v, tbl[i].e_e,
                        tbl[i].e_cnt, tbl[i].e_ovf);
        end
        idle_inputs();

        // Read-before-write on a freshly cleared bank.
        load_en = 1'b1; din = 32'hAA;
        tick();
        idle_inputs();
        upd_en = 1'b1; upd_addr = 3'd0; upd_din = 32'hBB; rd_en = 1'b1; rd_addr = 3'd0;
        tick();
        check_state("rbw_old", 32'hAA, 1'b1, 1'b0, 4'd1, 1'b0);
        idle_inputs();
        rd_en = 1'b1; rd_addr = 3'd0;
        tick();
        check_state("rbw_new", 32'hBB, 1'b1, 1'b0, 4'd1, 1'b0);
        idle_inputs();

        // Asynchronous reset between edges clears valid read data at once.
        #3;
        rst = 1'b1;
        #1;
        check_state("async_rst", 32'h0, 1'b0, 1'b0, 4'd0, 1'b0);
        tick();
        rst = 1'b0;

        // Reset racing a pending read: no dout_valid after release.
        load_en = 1'b1; din = 32'h11;
        tick();
        idle_inputs();
        rd_en = 1'b1; rd_addr = 3'd0;
        #2;
        rst = 1'b1;
        tick();
        check_state("rst_rd_hold", 32'h0, 1'b0, 1'b0, 4'd0, 1'b0);
        rd_en = 1'b0;
        #1;
        rst = 1'b0;
        tick();
        check_state("rst_rd_post", 32'h0, 1'b0, 1'b0, 4'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_theta_bank.md
REGFILE_THETA_BANK -- requirements
Module: regfile_theta_bank

Interface
REQ-001 SHALL have parameter DATA_W, default 32, entry width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, entry count, power of two, 2..64.
REQ-003 SHALL have parameter ADDR_W, default 3, equal to log2(DEPTH).
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-006 SHALL have port clr, input, 1, synchronous clear of bank contents and state.
REQ-007 SHALL have port load_en, input, 1, append din at the write pointer.
REQ-008 SHALL have port din, input, DATA_W, append data.
REQ-009 SHALL have port upd_en, input, 1, overwrite an existing entry.
REQ-010 SHALL have port upd_addr, input, ADDR_W, overwrite index.
REQ-011 SHALL have port upd_din, input, DATA_W, overwrite data.
REQ-012 SHALL have port rd_en, input, 1, read request.
REQ-013 SHALL have port rd_addr, input, ADDR_W, read index.
REQ-014 SHALL have port dout, output, DATA_W, registered read data.
REQ-015 SHALL have port dout_valid, output, 1, high for exactly the cycle after an accepted rd_en.
REQ-016 SHALL have port rd_err, output, 1, one-cycle pulse for a read of an unwritten index.
REQ-017 SHALL have port count, output, ADDR_W+1, number of valid entries, 0..DEPTH.
REQ-018 SHALL have ports full and empty, output, 1 each, meaning count==DEPTH and count==0.
REQ-019 SHALL have port ovf, output, 1, sticky flag set by a load while full.

Function
REQ-020 Load SHALL write din to entry count and increment count, provided full=0.
REQ-021 A load while full SHALL leave contents and count unchanged and set ovf.
REQ-022 An update with upd_addr<count SHALL overwrite that entry; one with upd_addr>=count SHALL be ignored.
REQ-023 If load and update occur in the same cycle, both SHALL take effect; the update is judged against the pre-cycle count.
REQ-024 A read with rd_addr<count (pre-edge count) SHALL present the entry on dout one cycle later with dout_valid=1.
REQ-025 A read with rd_addr>=count SHALL give dout_valid=1, dout=0 and rd_err=1 one cycle later.
REQ-026 A read and a write to the same index in one cycle SHALL return the old data (read-before-write).
REQ-027 When no read is accepted, dout_valid and rd_err SHALL be 0 in the next cycle.
REQ-028 clr SHALL set count to 0, ovf to 0, all entries to 0, dout_valid to 0 and rd_err to 0.
REQ-029 clr SHALL take priority over a load, update or read in the same cycle.
REQ-030 count SHALL saturate at DEPTH and never wrap; there is no pointer wrap-around.

Reset
REQ-031 rst SHALL asynchronously clear all entries, count, ovf, dout, dout_valid and rd_err to 0.
REQ-032 rst asserted mid-operation SHALL abort pending reads; no dout_valid SHALL follow the deassertion of rst.
REQ-033 After reset, empty SHALL be 1 and full SHALL be 0.

Configuration
REQ-034 Macro THETA_BANK_TRISTATE_EN, when defined, SHALL make dout high-impedance whenever dout_valid=0, for a shared bus.
REQ-035 Without THETA_BANK_TRISTATE_EN, dout SHALL hold its last registered value while dout_valid=0, and 0 after reset or clr.

Verification
REQ-036 Reset, then load 0x11,0x22,0x33, then read addr 1 -> next cycle dout=0x22, dout_valid=1, count=3.
REQ-037 Load 8 values with DEPTH=8, then load 0xFF -> full=1, count=8, ovf=1, entry 7 unchanged.
REQ-038 With count=2, read addr 5 -> dout=0, rd_err=1; upd_addr=5 -> no change.
REQ-039 Entry 0=0xAA; update addr 0 to 0xBB and read addr 0 in the same cycle -> dout=0xAA; a re-read gives 0xBB.
REQ-040 Assert clr together with a load -> count=0, ovf=0, next read of addr 0 gives rd_err=1.
REQ-041 Issue rd_en then assert rst the same cycle -> dout_valid stays 0; with TRISTATE_EN, dout=Z when idle.
